// File: rtl/result_output_stage_pkg.sv
// Shared types for the result output stage: IEEE-754 exception flags and
// the buffer's entry layout/occupancy encoding.
package exceptions;
    typedef struct packed {
        logic invalid;
        logic divide_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags;
endpackage

package result_output_stage_pkg;
    import exceptions::*;

    localparam int WORD_W  = 32;
    localparam int FLAGS_W = $bits(flags);
    localparam int ENTRY_W = FLAGS_W + WORD_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // Fields arrive already selected/rounded upstream; this is pure concatenation.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic        sign,
        input logic [7:0]  exponent,
        input logic        frac_msb,
        input logic [21:0] frac_lsbs
    );
        return {sign, exponent, frac_msb, frac_lsbs};
    endfunction
endpackage

// File: rtl/result_output_stage_if.sv
// Handshake and result bus of the result output stage.
interface result_output_stage_if;
    import exceptions::*;

    logic        in_valid;
    logic        in_ready;
    logic        result_sign;
    logic [7:0]  result_30_23;
    logic        result_22;
    logic [21:0] result_21_0;
    flags        in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    flags        out_flags;
    flags        sticky_flags;
    logic        clear_flags;
    logic        flush;

    modport master (
        output in_valid, result_sign, result_30_23, result_22, result_21_0,
               in_flags, out_ready, clear_flags, flush,
        input  in_ready, out_valid, result, out_flags, sticky_flags
    );

    modport slave (
        input  in_valid, result_sign, result_30_23, result_22, result_21_0,
               in_flags, out_ready, clear_flags, flush,
        output in_ready, out_valid, result, out_flags, sticky_flags
    );
endinterface

// File: rtl/result_output_stage_skid.sv
// Two-entry skid buffer (main output register + skid register) with a
// registered push_ready, so downstream ready never reaches upstream combinationally.
module result_skid_buffer
    import result_output_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [ENTRY_W-1:0] push_data,
    output logic               pop_valid,
    input  logic               pop_ready,
    output logic [ENTRY_W-1:0] pop_data
);
    occ_t               occ_reg;
    logic [ENTRY_W-1:0] main_reg;
    logic [ENTRY_W-1:0] skid_reg;
    logic               push_ready_reg;
    logic               pop_valid_reg;

    logic push;
    logic pop;

    assign push = push_valid && push_ready_reg;
    assign pop  = pop_valid_reg && pop_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_reg        <= OCC_EMPTY;
            main_reg       <= '0;
            skid_reg       <= '0;
            push_ready_reg <= 1'b1;
            pop_valid_reg  <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is dropped.
            occ_reg        <= OCC_EMPTY;
            push_ready_reg <= 1'b1;
            pop_valid_reg  <= 1'b0;
        end else begin
            case (occ_reg)
                OCC_EMPTY: begin
                    if (push) begin
                        main_reg      <= push_data;
                        occ_reg       <= OCC_ONE;
                        pop_valid_reg <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        main_reg <= push_data;
                    end else if (push) begin
                        skid_reg       <= push_data;
                        occ_reg        <= OCC_TWO;
                        push_ready_reg <= 1'b0;
                    end else if (pop) begin
                        occ_reg       <= OCC_EMPTY;
                        pop_valid_reg <= 1'b0;
                    end
                end
                OCC_TWO: begin
                    // push_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_reg       <= skid_reg;
                        occ_reg        <= OCC_ONE;
                        push_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    occ_reg        <= OCC_EMPTY;
                    push_ready_reg <= 1'b1;
                    pop_valid_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign push_ready = push_ready_reg;
    assign pop_valid  = pop_valid_reg;
    assign pop_data   = main_reg;
endmodule

// File: rtl/result_output_stage.sv
// Packs the selected sign/exponent/fraction fields into a binary32 word,
// buffers it with its flags, and accumulates sticky flags on commit.
module result_output_stage
    import exceptions::*;
    import result_output_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    result_output_stage_if.slave bus
);
    logic [WORD_W-1:0]  packed_word;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] pop_data;
    logic               pop_valid;
    logic               push_ready;
    logic               commit;
    flags               sticky_reg;

    assign packed_word = pack_word(bus.result_sign, bus.result_30_23,
                                   bus.result_22, bus.result_21_0);
    assign push_data   = {bus.in_flags, packed_word};

    result_skid_buffer u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.flush),
        .push_valid (bus.in_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (pop_data)
    );

    // A pop coinciding with flush is discarded, so it must not leave a sticky trace.
    assign commit = pop_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_reg <= '0;
        end else if (commit) begin
            sticky_reg <= (bus.clear_flags ? flags'('0) : sticky_reg)
                          | flags'(pop_data[ENTRY_W-1:WORD_W]);
        end else if (bus.clear_flags) begin
            sticky_reg <= '0;
        end
    end

    assign bus.in_ready     = push_ready;
    assign bus.out_valid    = pop_valid;
    assign bus.result       = pop_data[WORD_W-1:0];
    assign bus.out_flags    = flags'(pop_data[ENTRY_W-1:WORD_W]);
    assign bus.sticky_flags = sticky_reg;
endmodule

// File: tb/tb_result_output_stage.sv
// Randomized and directed bench for result_output_stage against a FIFO-queue
// reference model of the two-entry stage and its sticky flag accumulator.
module tb_result_output_stage;
    import exceptions::*;

    logic clk = 1'b0;
    logic reset;

    result_output_stage_if bus ();

    result_output_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] model_q[$];
    logic [4:0]  model_sticky = 5'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: a queue of at most two {flags, word} entries; ready is decided
    // by the occupancy seen at the start of the cycle.
    task automatic model_update(input logic iv, input logic [31:0] w, input logic [4:0] f,
                                input logic ordy, input logic clr, input logic fl);
        int  size_now;
        logic accept;
        size_now = model_q.size();
        accept   = iv && (size_now < 2) && !fl;
        if (fl) begin
            model_q.delete();
            if (clr) model_sticky = 5'd0;
        end else begin
            if (size_now > 0 && ordy) begin
                model_sticky = (clr ? 5'd0 : model_sticky) | model_q[0][36:32];
                $display("commit word=%08h flags=%05b sticky=%05b",
                         model_q[0][31:0], model_q[0][36:32], model_sticky);
                void'(model_q.pop_front());
            end else if (clr) begin
                model_sticky = 5'd0;
            end
            if (accept) model_q.push_back({f, w});
        end
    endtask

    task automatic compare_model();
        check("in_ready", 64'(bus.in_ready), 64'(model_q.size() < 2));
        check("out_valid", 64'(bus.out_valid), 64'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check("result", 64'(bus.result), 64'(model_q[0][31:0]));
            check("out_flags", 64'(bus.out_flags), 64'(model_q[0][36:32]));
        end
        check("sticky_flags", 64'(bus.sticky_flags), 64'(model_sticky));
    endtask

    // Drive one cycle at the negedge, let the edge happen, then compare at the next negedge.
    task automatic step(input logic iv, input logic [31:0] w, input logic [4:0] f,
                        input logic ordy, input logic clr, input logic fl);
        bus.in_valid     = iv;
        bus.result_sign  = w[31];
        bus.result_30_23 = w[30:23];
        bus.result_22    = w[22];
        bus.result_21_0  = w[21:0];
        bus.in_flags     = flags'(f);
        bus.out_ready    = ordy;
        bus.clear_flags  = clr;
        bus.flush        = fl;
        @(posedge clk);
        model_update(iv, w, f, ordy, clr, fl);
        @(negedge clk);
        compare_model();
    endtask

    logic [4:0] sticky_before;

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.result_sign = 1'b0; bus.result_30_23 = 8'd0;
        bus.result_22 = 1'b0; bus.result_21_0 = 22'd0; bus.in_flags = flags'(5'd0);
        bus.out_ready = 1'b0; bus.clear_flags = 1'b0; bus.flush = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_out_flags", 64'(bus.out_flags), 64'd0);
        check("rst_sticky", 64'(bus.sticky_flags), 64'd0);
        reset = 1'b0;

        // 1.0f from its fields, one-cycle latency
        step(1'b1, {1'b0, 8'h7F, 1'b0, 22'd0}, 5'd0, 1'b1, 1'b0, 1'b0);
        check("one_valid", 64'(bus.out_valid), 64'd1);
        check("one_result", 64'(bus.result), 64'h3F800000);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Fill both entries with downstream stalled, then drain
        step(1'b1, 32'h40000000, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h40400000, 5'd0, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_head", 64'(bus.result), 64'h40000000);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("drain_second", 64'(bus.result), 64'h40400000);
        check("drain_in_ready", 64'(bus.in_ready), 64'd1);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h1000 + 32'(i), 5'd0, 1'b1, 1'b0, 1'b0);
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            check("stream_result", 64'(bus.result), 64'h1000 + 64'(i));
        end
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Sticky accumulation and clear-with-commit
        step(1'b1, 32'h3F800001, 5'b00001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h7F800000, 5'b00100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("sticky_ovf_inx", 64'(bus.sticky_flags), 64'b00101);
        step(1'b1, 32'h00000001, 5'b00010, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("sticky_clear_unf", 64'(bus.sticky_flags), 64'b00010);

        // Flush at occupancy two with a concurrent push attempt
        step(1'b1, 32'hAAAA0000, 5'b10000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB0000, 5'b01000, 1'b0, 1'b0, 1'b0);
        sticky_before = 5'(bus.sticky_flags);
        step(1'b1, 32'hCCCC0000, 5'b11111, 1'b1, 1'b0, 1'b1);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_sticky", 64'(bus.sticky_flags), 64'b00010);
        check("flush_sticky_kept", 64'(bus.sticky_flags), 64'(sticky_before));

        // Asynchronous reset with two entries buffered
        step(1'b1, 32'h11110000, 5'b00001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h22220000, 5'b00100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33330000, 5'b00001, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_result", 64'(bus.result), 64'd0);
        check("arst_sticky", 64'(bus.sticky_flags), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        model_q.delete();
        model_sticky = 5'd0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h44440000, 5'b00010, 1'b0, 1'b0, 1'b0);
        check("post_rst_result", 64'(bus.result), 64'h44440000);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, 5'($urandom_range(0, 31)),
                 ($urandom % 3) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/result_output_stage.md
RESULT_OUTPUT_STAGE -- requirements
Module: result_output_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream result fields valid this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 result_sign  input  1  selected sign bit.
REQ-007 result_30_23  input  8  selected biased exponent.
REQ-008 result_22  input  1  selected fraction MSB (quiet bit).
REQ-009 result_21_0  input  22  selected fraction LSBs from the fraction-LSB selecter.
REQ-010 in_flags  input  exceptions::flags (5)  invalid, divide_by_zero, overflow, underflow, inexact for this result.
REQ-011 out_valid  output  1  packed result valid.
REQ-012 out_ready  input  1  downstream accepts packed result.
REQ-013 result  output  32  packed word {sign, exponent, fraction}.
REQ-014 out_flags  output  exceptions::flags  flags travelling with result.
REQ-015 sticky_flags  output  exceptions::flags  accumulated flags of all committed results.
REQ-016 clear_flags  input  1  clears sticky_flags.
REQ-017 flush  input  1  discards all buffered results.

Function
REQ-018 SHALL pack result = {result_sign, result_30_23, result_22, result_21_0} with no arithmetic or rounding.
REQ-019 SHALL accept (push) when in_valid && in_ready; SHALL commit (pop) when out_valid && out_ready.
REQ-020 SHALL buffer up to two entries (main output register + skid register); occupancy 0, 1 or 2.
REQ-021 in_ready SHALL be registered, high iff occupancy < 2 at start of cycle; no combinational path from out_ready to in_ready.
REQ-022 Latency push-to-out_valid SHALL be exactly 1 cycle when occupancy is 0, or 1 with simultaneous pop.
REQ-023 Occupancy 1, push and pop same cycle: new entry SHALL load main register, occupancy stays 1.
REQ-024 Occupancy 1, push without pop: new entry SHALL load skid register, occupancy 2, in_ready low next cycle.
REQ-025 Occupancy 2, pop: skid SHALL move to main, occupancy 1, in_ready high next cycle; no push possible this cycle.
REQ-026 Occupancy 0, pop impossible (out_valid low); result/out_flags SHALL hold last values (don't-care to consumer).
REQ-027 Order SHALL be strictly FIFO; no result dropped or duplicated while out_valid && !out_ready (outputs stable).
REQ-028 On commit, sticky_flags SHALL become (clear_flags ? 0 : sticky_flags) | committed out_flags.
REQ-029 clear_flags without commit SHALL zero sticky_flags next cycle.
REQ-030 flush SHALL set occupancy 0 next cycle, ignore any same-cycle push, and suppress sticky update from any same-cycle pop; sticky_flags otherwise unaffected.

Reset
REQ-031 Reset SHALL asynchronously force occupancy 0, out_valid 0, in_ready 1, result 32'h0, out_flags 0, sticky_flags 0, skid register 0.
REQ-032 Reset mid-operation SHALL discard buffered entries; first post-reset push behaves as from occupancy 0.

Structure
REQ-033 exceptions::flags packed struct (5 bits) SHALL live in the shared exceptions package used by the exception logic.
REQ-034 Packing and sticky logic SHALL stay in this module; the two-entry buffer SHALL be sub-module result_skid_buffer carrying 37-bit {flags, word}.

Verification
REQ-035 Push sign=0, exp=8'h7F, bit22=0, lsbs=0, flags=0, out_ready=1 -> next cycle out_valid=1, result=32'h3F800000.
REQ-036 out_ready=0, push 32'h40000000 then 32'h40400000 -> in_ready low after second push; raise out_ready -> both emerge in order, in_ready high again.
REQ-037 Back-to-back pushes with out_ready=1 for 8 cycles -> 8 results, one per cycle, in order, in_ready never low.
REQ-038 Commit result with inexact=1 then result with overflow=1 -> sticky_flags=5'b00101 (overflow|inexact); clear_flags with commit of underflow -> sticky=underflow only.
REQ-039 Occupancy 2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, sticky_flags unchanged.
REQ-040 Assert reset asynchronously mid-stream with occupancy 2 -> out_valid, result, sticky_flags zero immediately, in_ready=1.
